// File: rtl/dot_product_seq.sv
// dot_product_seq: drives a shared read port for two operand memories and
// multiply-accumulates VECTOR_WIDTH pairs per vector, streaming one result each.
module dot_product_seq #(
    parameter int DATA_WIDTH   = 8,
    parameter int VECTOR_WIDTH = 4,
    parameter int ADDR_WIDTH   = 5,
    parameter int ACC_WIDTH    = 18
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH-1:0] num_vectors,
    output logic                  busy,
    output logic                  done,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] mem1_data,
    input  logic [DATA_WIDTH-1:0] mem2_data,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [ACC_WIDTH-1:0]  res_data,
    output logic [ADDR_WIDTH-1:0] res_index
);

    localparam int CW = (VECTOR_WIDTH > 1) ? $clog2(VECTOR_WIDTH) : 1;
    localparam logic [ADDR_WIDTH-1:0] A_ONE = 1;
    localparam logic [CW-1:0]         C_ONE = 1;
    localparam logic [CW-1:0]         C_LAST = CW'(VECTOR_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_DRAIN,
        S_OUT,
        S_DONE
    } state_t;

    state_t                state_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  rd_en_q;
    logic                  rd_en_dly_q;
    logic [ADDR_WIDTH-1:0] rd_addr_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH-1:0] num_q;
    logic [ADDR_WIDTH-1:0] vec_q;
    logic [CW-1:0]         elem_q;
    logic [ACC_WIDTH-1:0]  acc_q;
    logic [ACC_WIDTH-1:0]  acc_d;
    logic                  res_valid_q;
    logic [ACC_WIDTH-1:0]  res_data_q;
    logic [ADDR_WIDTH-1:0] res_index_q;
    logic [2*DATA_WIDTH-1:0] prod;

    // Unsigned product of the current element pair, added into the running sum.
    always_comb begin
        prod  = (2*DATA_WIDTH)'(mem1_data) * (2*DATA_WIDTH)'(mem2_data);
        acc_d = acc_q + ACC_WIDTH'(prod);
    end

    // Sequencer FSM with registered outputs and the MAC accumulator.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rd_en_q     <= 1'b0;
            rd_en_dly_q <= 1'b0;
            rd_addr_q   <= '0;
            addr_q      <= '0;
            num_q       <= '0;
            vec_q       <= '0;
            elem_q      <= '0;
            acc_q       <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_index_q <= '0;
        end else begin
            done_q      <= 1'b0;
            rd_en_dly_q <= rd_en_q;
            if (rd_en_dly_q) begin
                acc_q <= acc_d;
            end
            if (abort && state_q != S_IDLE) begin
                state_q     <= S_IDLE;
                busy_q      <= 1'b0;
                rd_en_q     <= 1'b0;
                rd_en_dly_q <= 1'b0;
                res_valid_q <= 1'b0;
            end else begin
                unique case (state_q)
                    S_IDLE: begin
                        if (start && !abort) begin
                            busy_q <= 1'b1;
                            num_q  <= num_vectors;
                            vec_q  <= '0;
                            if (num_vectors == '0) begin
                                state_q <= S_DONE;
                            end else begin
                                state_q   <= S_READ;
                                rd_en_q   <= 1'b1;
                                rd_addr_q <= base_addr;
                                addr_q    <= base_addr + A_ONE;
                                elem_q    <= '0;
                                acc_q     <= '0;
                            end
                        end
                    end
                    S_READ: begin
                        if (elem_q == C_LAST) begin
                            rd_en_q <= 1'b0;
                            state_q <= S_DRAIN;
                        end else begin
                            rd_addr_q <= addr_q;
                            addr_q    <= addr_q + A_ONE;
                            elem_q    <= elem_q + C_ONE;
                        end
                    end
                    S_DRAIN: begin
                        res_data_q  <= acc_d;
                        res_index_q <= vec_q;
                        res_valid_q <= 1'b1;
                        state_q     <= S_OUT;
                    end
                    S_OUT: begin
                        if (res_ready) begin
                            res_valid_q <= 1'b0;
                            if (vec_q == num_q - A_ONE) begin
                                state_q <= S_DONE;
                            end else begin
                                vec_q     <= vec_q + A_ONE;
                                state_q   <= S_READ;
                                rd_en_q   <= 1'b1;
                                rd_addr_q <= addr_q;
                                addr_q    <= addr_q + A_ONE;
                                elem_q    <= '0;
                                acc_q     <= '0;
                            end
                        end
                    end
                    S_DONE: begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign rd_en     = rd_en_q;
    assign rd_addr   = rd_addr_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_index = res_index_q;

endmodule

// File: tb/tb_dot_product_seq.sv
// tb_dot_product_seq: directed vectors with a result scoreboard drained by
// an independent monitor; memories modelled with one-cycle registered reads.
module tb_dot_product_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [4:0]  base_addr;
    logic [4:0]  num_vectors;
    logic        busy;
    logic        done;
    logic        rd_en;
    logic [4:0]  rd_addr;
    logic [7:0]  mem1_data;
    logic [7:0]  mem2_data;
    logic        res_valid;
    logic        res_ready;
    logic [17:0] res_data;
    logic [4:0]  res_index;

    typedef struct {
        int d;
        int i;
    } exp_t;

    exp_t exp_q[$];
    int   rd_log[$];
    logic [7:0] m1[32];
    logic [7:0] m2[32];
    int   total = 0;
    int   bad = 0;
    int   done_cnt = 0;
    logic stall = 1'b0;
    int   hold_d;
    int   hold_i;

    dot_product_seq #(
        .DATA_WIDTH(8),
        .VECTOR_WIDTH(4),
        .ADDR_WIDTH(5),
        .ACC_WIDTH(18)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .abort(abort),
        .base_addr(base_addr),
        .num_vectors(num_vectors),
        .busy(busy),
        .done(done),
        .rd_en(rd_en),
        .rd_addr(rd_addr),
        .mem1_data(mem1_data),
        .mem2_data(mem2_data),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .res_data(res_data),
        .res_index(res_index)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rd_en) begin
            mem1_data <= m1[rd_addr];
            mem2_data <= m2[rd_addr];
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            stall = 1'b0;
        end else begin
            if (rd_en) rd_log.push_back(int'(rd_addr));
            if (done) done_cnt++;
            if (stall && res_valid) begin
                chk("hold_data", int'(res_data), hold_d);
                chk("hold_index", int'(res_index), hold_i);
            end
            if (res_valid && res_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_result got=%0d want=none",
                             res_data);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("res_data", int'(res_data), e.d);
                    chk("res_index", int'(res_index), e.i);
                end
            end
            stall  = res_valid && !res_ready;
            hold_d = int'(res_data);
            hold_i = int'(res_index);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic go(input int b, input int n);
        base_addr   = 5'(b);
        num_vectors = 5'(n);
        start       = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic push(input int d, input int i);
        exp_t e;
        e.d = d;
        e.i = i;
        exp_q.push_back(e);
    endtask

    task automatic wait_done(input int max);
        int c0;
        int n;
        c0 = done_cnt;
        n = 0;
        while (done_cnt == c0 && n < max) begin
            tick();
            n++;
        end
        chk("done_seen", int'(done_cnt != c0), 1);
    endtask

    task automatic wait_valid(input int max);
        int n;
        n = 0;
        while (!res_valid && n < max) begin
            tick();
            n++;
        end
        chk("valid_seen", int'(res_valid), 1);
    endtask

    task automatic fill_ramp();
        for (int k = 0; k < 32; k++) begin
            m1[k] = 8'(k + 1);
            m2[k] = 8'd2;
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_rd_en"}, int'(rd_en), 0);
        chk({tag, "_res_valid"}, int'(res_valid), 0);
        chk({tag, "_rd_addr"}, int'(rd_addr), 0);
        chk({tag, "_res_data"}, int'(res_data), 0);
        chk({tag, "_res_index"}, int'(res_index), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        rst_n       = 1'b0;
        start       = 1'b0;
        abort       = 1'b0;
        base_addr   = '0;
        num_vectors = '0;
        res_ready   = 1'b1;
        fill_ramp();
        repeat (3) tick();
        chk_zero("reset");
        rst_n = 1'b1;
        tick();

        // single vector with cycle-exact timing
        rd_log.delete();
        push(20, 0);
        go(0, 1);
        chk("t1_busy", int'(busy), 1);
        for (int k = 0; k < 4; k++) begin
            chk("t1_rd_en", int'(rd_en), 1);
            chk("t1_rd_addr", int'(rd_addr), k);
            tick();
        end
        chk("t1_rd_en_off", int'(rd_en), 0);
        tick();
        chk("t1_valid_c6", int'(res_valid), 1);
        tick();
        chk("t1_done_c7", int'(done), 0);
        tick();
        chk("t1_done_c8", int'(done), 1);
        chk("t1_busy_c8", int'(busy), 0);
        tick();
        chk("t1_drained", exp_q.size(), 0);

        // two vectors with backpressure
        res_ready = 1'b0;
        rd_log.delete();
        d0 = done_cnt;
        push(20, 0);
        push(52, 1);
        go(0, 2);
        wait_valid(20);
        repeat (3) tick();
        res_ready = 1'b1;
        wait_done(40);
        repeat (3) tick();
        chk("t2_done_pulses", done_cnt - d0, 1);
        chk("t2_reads", rd_log.size(), 8);
        for (int k = 0; k < 8 && k < rd_log.size(); k++) begin
            chk("t2_addr", rd_log[k], k);
        end
        chk("t2_drained", exp_q.size(), 0);

        // full-scale operands
        for (int k = 0; k < 32; k++) begin
            m1[k] = 8'hff;
            m2[k] = 8'hff;
        end
        push(260100, 0);
        go(0, 1);
        wait_done(30);
        chk("t3_drained", exp_q.size(), 0);

        // address wrap
        fill_ramp();
        rd_log.delete();
        push(132, 0);
        go(30, 1);
        wait_done(30);
        chk("t4_reads", rd_log.size(), 4);
        if (rd_log.size() == 4) begin
            chk("t4_a0", rd_log[0], 30);
            chk("t4_a1", rd_log[1], 31);
            chk("t4_a2", rd_log[2], 0);
            chk("t4_a3", rd_log[3], 1);
        end
        chk("t4_drained", exp_q.size(), 0);

        // zero vectors
        rd_log.delete();
        go(0, 0);
        chk("t5_done_c1", int'(done), 0);
        tick();
        chk("t5_done_c2", int'(done), 1);
        chk("t5_busy_c2", int'(busy), 0);
        tick();
        chk("t5_no_reads", rd_log.size(), 0);

        // start while busy is ignored
        rd_log.delete();
        push(84, 0);
        go(8, 1);
        tick();
        tick();
        base_addr   = 5'd20;
        num_vectors = 5'd3;
        start       = 1'b1;
        tick();
        start = 1'b0;
        wait_done(30);
        repeat (10) tick();
        chk("t6_reads", rd_log.size(), 4);
        for (int k = 0; k < 4 && k < rd_log.size(); k++) begin
            chk("t6_addr", rd_log[k], 8 + k);
        end
        chk("t6_drained", exp_q.size(), 0);

        // synchronous reset in second READ cycle
        push(20, 0);
        go(0, 1);
        tick();
        rst_n = 1'b0;
        tick();
        chk_zero("t7");
        rst_n = 1'b1;
        exp_q.delete();
        repeat (8) tick();
        chk("t7_idle", int'(busy), 0);

        // abort while holding a result
        res_ready = 1'b0;
        push(20, 0);
        go(0, 1);
        wait_valid(20);
        d0 = done_cnt;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t8_valid", int'(res_valid), 0);
        chk("t8_busy", int'(busy), 0);
        repeat (4) tick();
        chk("t8_no_done", done_cnt - d0, 0);
        exp_q.delete();
        res_ready = 1'b1;
        push(52, 0);
        go(4, 1);
        wait_done(30);
        tick();
        chk("t8_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
